// File: rtl/spi_rx_deserializer.sv
// SPI receive-path deserializer: packs the master's bit stream MSB-first
// into bytes, buffers them in a FWFT FIFO and reports per-frame status.
module spi_rx_deserializer #(
  parameter int FIFO_DEPTH  = 16,
  parameter bit PAD_PARTIAL = 1'b1,
  parameter int CNT_W       = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             frame_active_i,
  input  logic             clr_err_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [AW:0]      fifo_level_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] frame_bytes_o,
  output logic             overflow_o,
  output logic             partial_err_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_RECV, S_FLUSH, S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  state_t state_q, state_d;

  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fbytes_q, fbytes_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic       push_req;
  logic [7:0] push_byte;
  logic       push_ok;
  logic       pop;
  logic       full;
  logic       cnt_clr;
  logic       perr_set;
  logic       ovf_set;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (frame_active_i) state_d = S_RECV;
      S_RECV:  if (!frame_active_i) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_done_o  = (state_q == S_DONE);
    frame_bytes_o = fbytes_q;
    overflow_o    = ovf_q;
    partial_err_o = perr_q;
    fifo_level_o  = level_q;
    rx_valid_o    = (level_q != '0);
    rx_data_o     = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  end

  // Bit packing and frame bookkeeping
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push_req  = 1'b0;
    push_byte = 8'h00;
    cnt_clr   = 1'b0;
    perr_set  = 1'b0;
    fbytes_d  = fbytes_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_active_i) begin
          cnt_clr   = 1'b1;
          bit_cnt_d = 3'd0;
          if (bit_valid_i) begin
            shift_d   = {shift_q[6:0], bit_i};
            bit_cnt_d = 3'd1;
          end
        end
      end
      S_RECV: begin
        if (frame_active_i && bit_valid_i) begin
          shift_d   = {shift_q[6:0], bit_i};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_req  = 1'b1;
            push_byte = {shift_q[6:0], bit_i};
          end
        end
      end
      S_FLUSH: begin
        if (bit_cnt_q != 3'd0) begin
          perr_set  = 1'b1;
          push_req  = PAD_PARTIAL;
          push_byte = shift_q << (4'd8 - {1'b0, bit_cnt_q});
        end
        bit_cnt_d = 3'd0;
      end
      S_DONE: fbytes_d = cnt_q;
    endcase
  end

  always_comb begin
    pop      = rx_valid_o && rx_ready_i;
    full     = (level_q == DEPTH_L);
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop) level_d = level_q - (AW+1)'(1);
    cnt_d = cnt_q;
    if (cnt_clr)                      cnt_d = '0;
    else if (push_ok && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
    // Set beats clear when both land in the same cycle
    ovf_d  = ovf_set  | (ovf_q  & ~clr_err_i);
    perr_d = perr_set | (perr_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      fbytes_q  <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      fbytes_q  <= fbytes_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer; a second instance runs with
// trailing-partial padding disabled on the same stimulus.
module tb_spi_rx_deserializer;

  logic        clk;
  logic        rst_n;
  logic        bit_valid;
  logic        bit_in;
  logic        frame_active;
  logic        clr_err;
  logic        rx_ready;

  logic [7:0]  data1, data0;
  logic        valid1, valid0;
  logic [4:0]  level1, level0;
  logic        done1, done0;
  logic [15:0] fbytes1, fbytes0;
  logic        ovf1, ovf0;
  logic        perr1, perr0;

  int checks;
  int failures;

  spi_rx_deserializer #(
    .FIFO_DEPTH(16), .PAD_PARTIAL(1'b1), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .bit_valid_i(bit_valid), .bit_i(bit_in),
    .frame_active_i(frame_active), .clr_err_i(clr_err),
    .rx_data_o(data1), .rx_valid_o(valid1), .rx_ready_i(rx_ready),
    .fifo_level_o(level1), .frame_done_o(done1),
    .frame_bytes_o(fbytes1), .overflow_o(ovf1),
    .partial_err_o(perr1)
  );

  spi_rx_deserializer #(
    .FIFO_DEPTH(16), .PAD_PARTIAL(1'b0), .CNT_W(16)
  ) dut_nopad (
    .clk_i(clk), .rst_ni(rst_n),
    .bit_valid_i(bit_valid), .bit_i(bit_in),
    .frame_active_i(frame_active), .clr_err_i(clr_err),
    .rx_data_o(data0), .rx_valid_o(valid0), .rx_ready_i(rx_ready),
    .fifo_level_o(level0), .frame_done_o(done0),
    .frame_bytes_o(fbytes0), .overflow_o(ovf0),
    .partial_err_o(perr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_frame(output int pulses);
    frame_active = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      if (done1) pulses++;
    end
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid1); end
    checks++; if (data1 !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data1); end
    checks++; if (level1 !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done1); end
    checks++; if (fbytes1 !== 16'd0) begin failures++; $display("FAIL rst_fbytes got=%0d exp=0", fbytes1); end
    checks++; if ({ovf1, perr1} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {ovf1, perr1}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int p;
    rx_ready = 1'b1;
    frame_active = 1'b1;
    send_byte(8'hA5);
    checks++; if ({valid1, data1} !== {1'b1, 8'hA5}) begin failures++; $display("FAIL basic_b0 got=%b/%h exp=1/a5", valid1, data1); end
    send_byte(8'h3C);
    checks++; if ({valid1, data1} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL basic_b1 got=%b/%h exp=1/3c", valid1, data1); end
    end_frame(p);
    rx_ready = 1'b0;
    checks++; if (p !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", p); end
    checks++; if (fbytes1 !== 16'd2) begin failures++; $display("FAIL basic_fbytes got=%0d exp=2", fbytes1); end
    checks++; if ({ovf1, perr1} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {ovf1, perr1}); end
    checks++; if (level1 !== 5'd0) begin failures++; $display("FAIL basic_level got=%0d exp=0", level1); end
  endtask

  task automatic test_partial();
    int p;
    frame_active = 1'b1;
    send_byte(8'hFF);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    end_frame(p);
    checks++; if (p !== 1) begin failures++; $display("FAIL part_done got=%0d exp=1", p); end
    checks++; if (level1 !== 5'd2) begin failures++; $display("FAIL part_level_pad got=%0d exp=2", level1); end
    checks++; if (level0 !== 5'd1) begin failures++; $display("FAIL part_level_nopad got=%0d exp=1", level0); end
    checks++; if ({perr1, perr0} !== 2'b11) begin failures++; $display("FAIL part_err got=%b exp=11", {perr1, perr0}); end
    checks++; if (fbytes1 !== 16'd2) begin failures++; $display("FAIL part_fbytes_pad got=%0d exp=2", fbytes1); end
    checks++; if (fbytes0 !== 16'd1) begin failures++; $display("FAIL part_fbytes_nopad got=%0d exp=1", fbytes0); end
    checks++; if ({data1, data0} !== 16'hFFFF) begin failures++; $display("FAIL part_head got=%h/%h exp=ff/ff", data1, data0); end
    pop();
    checks++; if ({valid1, data1} !== {1'b1, 8'hA0}) begin failures++; $display("FAIL part_pad_byte got=%b/%h exp=1/a0", valid1, data1); end
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL part_nopad_empty got=%b exp=0", valid0); end
    pop();
    pulse_clr();
    checks++; if ({perr1, perr0} !== 2'b00) begin failures++; $display("FAIL part_clr got=%b exp=00", {perr1, perr0}); end
  endtask

  task automatic test_overflow();
    int p;
    frame_active = 1'b1;
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    end_frame(p);
    checks++; if (level1 !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", level1); end
    checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf1); end
    checks++; if (fbytes1 !== 16'd16) begin failures++; $display("FAIL ovf_fbytes got=%0d exp=16", fbytes1); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (data1 !== 8'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, data1, 8'(i)); end
      pop();
    end
    checks++; if (level1 !== 5'd0) begin failures++; $display("FAIL ovf_empty got=%0d exp=0", level1); end
    pulse_clr();
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf1); end
  endtask

  task automatic test_full_pop();
    int p;
    logic [7:0] v;
    logic [7:0] exp;
    v = 8'h77;
    frame_active = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
    checks++; if ({level1, ovf1} !== {5'd16, 1'b0}) begin failures++; $display("FAIL fp_fill got=%0d/%b exp=16/0", level1, ovf1); end
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    rx_ready = 1'b1;
    send_bit(v[0]);
    rx_ready = 1'b0;
    checks++; if (level1 !== 5'd16) begin failures++; $display("FAIL fp_level got=%0d exp=16", level1); end
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL fp_ovf got=%b exp=0", ovf1); end
    end_frame(p);
    checks++; if (fbytes1 !== 16'd17) begin failures++; $display("FAIL fp_fbytes got=%0d exp=17", fbytes1); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h77 : 8'h81 + 8'(i);
      checks++; if (data1 !== exp) begin failures++; $display("FAIL fp_drain%0d got=%h exp=%h", i, data1, exp); end
      pop();
    end
  endtask

  task automatic test_gapped_reset();
    int p;
    logic [7:0] v;
    v = 8'h5A;
    frame_active = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i != 0) repeat (2) tick();
    end
    checks++; if ({valid1, data1} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL gap_byte got=%b/%h exp=1/5a", valid1, data1); end
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rst_n = 1'b0;
    frame_active = 1'b0;
    tick();
    checks++; if ({valid1, data1, level1} !== {1'b1 == 1'b0, 8'h00, 5'd0}) begin failures++; $display("FAIL mid_rst_fifo got=%b/%h/%0d exp=0/00/0", valid1, data1, level1); end
    checks++; if ({done1, fbytes1} !== {1'b0, 16'd0}) begin failures++; $display("FAIL mid_rst_frame got=%b/%0d exp=0/0", done1, fbytes1); end
    checks++; if ({ovf1, perr1} !== 2'b00) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00", {ovf1, perr1}); end
    rst_n = 1'b1;
    tick();
    frame_active = 1'b1;
    send_byte(8'h81);
    checks++; if ({valid1, data1} !== {1'b1, 8'h81}) begin failures++; $display("FAIL post_rst_byte got=%b/%h exp=1/81", valid1, data1); end
    end_frame(p);
    checks++; if ({p[1:0], fbytes1} !== {2'd1, 16'd1}) begin failures++; $display("FAIL post_rst_frame got=%0d/%0d exp=1/1", p, fbytes1); end
    checks++; if (perr1 !== 1'b0) begin failures++; $display("FAIL post_rst_perr got=%b exp=0", perr1); end
    pop();
  endtask

  task automatic test_back_to_back();
    int p;
    rx_ready = 1'b1;
    frame_active = 1'b1;
    send_byte(8'h11);
    checks++; if ({valid1, data1} !== {1'b1, 8'h11}) begin failures++; $display("FAIL b2b_b0 got=%b/%h exp=1/11", valid1, data1); end
    frame_active = 1'b0;
    tick();
    frame_active = 1'b1;
    tick();
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL b2b_done0 got=%b exp=1", done1); end
    tick();
    checks++; if ({done1, fbytes1} !== {1'b0, 16'd1}) begin failures++; $display("FAIL b2b_fbytes0 got=%b/%0d exp=0/1", done1, fbytes1); end
    send_byte(8'h22);
    checks++; if ({valid1, data1} !== {1'b1, 8'h22}) begin failures++; $display("FAIL b2b_b1 got=%b/%h exp=1/22", valid1, data1); end
    end_frame(p);
    rx_ready = 1'b0;
    checks++; if (p !== 1) begin failures++; $display("FAIL b2b_done1 got=%0d exp=1", p); end
    checks++; if (fbytes1 !== 16'd1) begin failures++; $display("FAIL b2b_fbytes1 got=%0d exp=1", fbytes1); end
    checks++; if (level1 !== 5'd0) begin failures++; $display("FAIL b2b_level got=%0d exp=0", level1); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bit_valid    = 1'b0;
    bit_in       = 1'b0;
    frame_active = 1'b0;
    clr_err      = 1'b0;
    rx_ready     = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_overflow();
    test_full_pop();
    test_gapped_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
